// File: rtl/systolic_pkg.sv
// Shared state encoding and sizing helpers for the systolic operand feeder.
package systolic_pkg;

   localparam int ARR_SIZE_DEF      = 4;
   localparam int HORIZONTAL_BW_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } feed_state_t;

   // One counter serves both phases: it must reach 2N-2 while streaming and DRAIN_CYCLES-1 while draining.
   function automatic int cnt_width(input int arr_size, input int drain_cycles);
      int span;
      span = 2 * arr_size - 1;
      if (drain_cycles > span) span = drain_cycles;
      return (span < 2) ? 1 : $clog2(span);
   endfunction

endpackage

// File: rtl/skew_lane_sel.sv
// Picks element (cnt - LANE) of an N-element vector, or 0 outside the lane's diagonal window.
// Purely combinational; no handshake.
module skew_lane_sel
   import systolic_pkg::*;
#(
   parameter int ARR_SIZE = ARR_SIZE_DEF,
   parameter int BW       = HORIZONTAL_BW_DEF,
   parameter int CNT_W    = 3,
   parameter int LANE     = 0
) (
   input  logic [CNT_W-1:0]       cnt,
   input  logic [BW*ARR_SIZE-1:0] vec,
   output logic [BW-1:0]          elem
);

   always_comb begin
      elem = '0;
      for (int k = 0; k < ARR_SIZE; k++) begin
         if (int'(cnt) == k + LANE) elem = vec[k*BW +: BW];
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers operand matrices A (rows) and B (columns) and streams them diagonally skewed into the MAC array.
// First lane data one cycle after start; start and writes are dropped while busy, there is no backpressure.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int ARR_SIZE      = ARR_SIZE_DEF,
   parameter int HORIZONTAL_BW = HORIZONTAL_BW_DEF,
   parameter int DRAIN_CYCLES  = 8,
   parameter int IDX_W         = $clog2(ARR_SIZE)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wr_en,
   input  logic                              wr_sel,
   input  logic [IDX_W-1:0]                  wr_idx,
   input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] wr_data,
   input  logic                              start,
   output logic [HORIZONTAL_BW*ARR_SIZE-1:0] horizontal_input,
   output logic [HORIZONTAL_BW*ARR_SIZE-1:0] vertical_input,
   output logic                              feed_valid,
   output logic                              busy,
   output logic                              done
);

   localparam int LANE_W = HORIZONTAL_BW * ARR_SIZE;
   localparam int CNT_W  = cnt_width(ARR_SIZE, DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(2 * ARR_SIZE - 2);
   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   feed_state_t                     state;
   feed_state_t                     state_nxt;
   logic [CNT_W-1:0]                cnt;
   logic [CNT_W-1:0]                cnt_nxt;
   logic [ARR_SIZE-1:0][LANE_W-1:0] a_rows;
   logic [ARR_SIZE-1:0][LANE_W-1:0] a_rows_nxt;
   logic [ARR_SIZE-1:0][LANE_W-1:0] b_cols;
   logic [ARR_SIZE-1:0][LANE_W-1:0] b_cols_nxt;
   logic [LANE_W-1:0]               h_sel;
   logic [LANE_W-1:0]               v_sel;
   logic                            wr_ok;

   assign wr_ok = wr_en && (state == ST_IDLE) && (int'(wr_idx) < ARR_SIZE);

   // Lane selectors see the post-write buffers so a write issued together with start is streamed.
   always_comb begin
      a_rows_nxt = a_rows;
      b_cols_nxt = b_cols;
      if (wr_ok) begin
         if (wr_sel) b_cols_nxt[wr_idx] = wr_data;
         else        a_rows_nxt[wr_idx] = wr_data;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_STREAM;
               cnt_nxt   = '0;
            end
         end
         ST_STREAM: begin
            if (cnt == STREAM_LAST) begin
               state_nxt = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (cnt == DRAIN_LAST) begin
               state_nxt = ST_DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
      skew_lane_sel #(
         .ARR_SIZE (ARR_SIZE),
         .BW       (HORIZONTAL_BW),
         .CNT_W    (CNT_W),
         .LANE     (i)
      ) u_h_sel (
         .cnt  (cnt_nxt),
         .vec  (a_rows_nxt[i]),
         .elem (h_sel[i*HORIZONTAL_BW +: HORIZONTAL_BW])
      );

      skew_lane_sel #(
         .ARR_SIZE (ARR_SIZE),
         .BW       (HORIZONTAL_BW),
         .CNT_W    (CNT_W),
         .LANE     (i)
      ) u_v_sel (
         .cnt  (cnt_nxt),
         .vec  (b_cols_nxt[i]),
         .elem (v_sel[i*HORIZONTAL_BW +: HORIZONTAL_BW])
      );
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= ST_IDLE;
         cnt              <= '0;
         a_rows           <= '0;
         b_cols           <= '0;
         horizontal_input <= '0;
         vertical_input   <= '0;
         feed_valid       <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         state            <= state_nxt;
         cnt              <= cnt_nxt;
         a_rows           <= a_rows_nxt;
         b_cols           <= b_cols_nxt;
         horizontal_input <= (state_nxt == ST_STREAM) ? h_sel : '0;
         vertical_input   <= (state_nxt == ST_STREAM) ? v_sel : '0;
         feed_valid       <= (state_nxt == ST_STREAM);
         busy             <= (state_nxt != ST_IDLE);
         done             <= (state_nxt == ST_DONE);
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus pushes expected stream beats and done cycles, a negedge monitor checks them.
module tb_systolic_feeder;

   localparam int N     = 4;
   localparam int BW    = 16;
   localparam int W     = N * BW;
   localparam int DRAIN = 8;

   logic         clk     = 1'b0;
   logic         rst     = 1'b0;
   logic         wr_en   = 1'b0;
   logic         wr_sel  = 1'b0;
   logic [1:0]   wr_idx  = '0;
   logic [W-1:0] wr_data = '0;
   logic         start   = 1'b0;
   logic [W-1:0] horizontal_input;
   logic [W-1:0] vertical_input;
   logic         feed_valid;
   logic         busy;
   logic         done;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   typedef struct {
      int           cyc;
      logic [W-1:0] h;
      logic [W-1:0] v;
   } beat_t;

   beat_t         feed_q[$];
   int            done_q[$];
   int            busy_lo = 1;
   int            busy_hi = 0;
   int            fv_lo   = 1;
   int            fv_hi   = 0;
   logic [BW-1:0] ma [N][N];
   logic [BW-1:0] mb [N][N];

   systolic_feeder #(
      .ARR_SIZE      (N),
      .HORIZONTAL_BW (BW),
      .DRAIN_CYCLES  (DRAIN)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .wr_en            (wr_en),
      .wr_sel           (wr_sel),
      .wr_idx           (wr_idx),
      .wr_data          (wr_data),
      .start            (start),
      .horizontal_input (horizontal_input),
      .vertical_input   (vertical_input),
      .feed_valid       (feed_valid),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_h(input int t);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) r[i*BW +: BW] = ma[i][t-i];
      return r;
   endfunction

   function automatic logic [W-1:0] ref_v(input int t);
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < N; j++)
         if (t - j >= 0 && t - j < N) r[j*BW +: BW] = mb[t-j][j];
      return r;
   endfunction

   function automatic bit model_idle(input int x);
      return !(x >= busy_lo && x <= busy_hi);
   endfunction

   task automatic model_clear();
      for (int r = 0; r < N; r++)
         for (int k = 0; k < N; k++) begin
            ma[r][k] = '0;
            mb[r][k] = '0;
         end
      feed_q.delete();
      done_q.delete();
      busy_lo = 1; busy_hi = 0;
      fv_lo   = 1; fv_hi   = 0;
   endtask

   task automatic apply_write(input bit sel, input int idx, input logic [W-1:0] data);
      for (int k = 0; k < N; k++) begin
         if (!sel) ma[idx][k] = data[k*BW +: BW];
         else      mb[k][idx] = data[k*BW +: BW];
      end
   endtask

   task automatic accept(input int x);
      for (int t = 0; t < 2 * N - 1; t++)
         feed_q.push_back(beat_t'{x + 1 + t, ref_h(t), ref_v(t)});
      done_q.push_back(x + 2 * N + DRAIN);
      busy_lo = x + 1; busy_hi = x + 2 * N + DRAIN;
      fv_lo   = x + 1; fv_hi   = x + 2 * N - 1;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk_bus(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      beat_t b;
      int    d;
      bit    efv, ebusy, edone;
      while (feed_q.size() > 0 && feed_q[0].cyc < cyc) begin
         b = feed_q.pop_front();
         vectors++; miscompares++;
         $display("FAIL beat_missing: beat due at cycle %0d not seen, now cycle %0d", b.cyc, cyc);
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
         d = done_q.pop_front();
         vectors++; miscompares++;
         $display("FAIL done_missing: done due at cycle %0d not seen, now cycle %0d", d, cyc);
      end
      efv   = (cyc >= fv_lo && cyc <= fv_hi);
      ebusy = (cyc >= busy_lo && cyc <= busy_hi);
      edone = (done_q.size() > 0 && done_q[0] == cyc);
      vectors++;
      if ({feed_valid, busy, done} !== {efv, ebusy, edone}) begin
         miscompares++;
         $display("FAIL status: got fv/busy/done=%b%b%b expected %b%b%b (cycle %0d)",
                  feed_valid, busy, done, efv, ebusy, edone, cyc);
      end
      vectors++;
      if (feed_valid === 1'b1) begin
         if (feed_q.size() == 0) begin
            miscompares++;
            $display("FAIL beat_unexpected: h=%h v=%h (cycle %0d)", horizontal_input, vertical_input, cyc);
         end else begin
            b = feed_q.pop_front();
            if (b.cyc != cyc || horizontal_input !== b.h || vertical_input !== b.v) begin
               miscompares++;
               $display("FAIL beat: got cyc %0d h=%h v=%h expected cyc %0d h=%h v=%h",
                        cyc, horizontal_input, vertical_input, b.cyc, b.h, b.v);
            end
         end
      end else if (horizontal_input !== '0 || vertical_input !== '0) begin
         miscompares++;
         $display("FAIL idle_bus: got h=%h v=%h expected zero (cycle %0d)", horizontal_input, vertical_input, cyc);
      end
      if (done === 1'b1) begin
         vectors++;
         if (done_q.size() == 0) begin
            miscompares++;
            $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
         end else begin
            d = done_q.pop_front();
            if (d != cyc) begin
               miscompares++;
               $display("FAIL done_cycle: got %0d expected %0d", cyc, d);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit we, input bit sel, input int idx, input logic [W-1:0] data,
                        input bit st, output int x);
      @(negedge clk);
      x       = cyc;
      wr_en   = we;
      wr_sel  = sel;
      wr_idx  = 2'(idx);
      wr_data = data;
      start   = st;
      if (model_idle(x)) begin
         if (we && idx < N) apply_write(sel, idx, data);
         if (st) accept(x);
      end
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_pattern();
      logic [W-1:0] d;
      int           x;
      for (int r = 0; r < N; r++) begin
         for (int k = 0; k < N; k++) d[k*BW +: BW] = BW'(16 * r + k);
         drive(1'b1, 1'b0, r, d, 1'b0, x);
      end
      for (int c = 0; c < N; c++) begin
         for (int k = 0; k < N; k++) d[k*BW +: BW] = BW'(32'h100 + 16 * k + c);
         drive(1'b1, 1'b1, c, d, 1'b0, x);
      end
   endtask

   task automatic load_random();
      int x;
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < N; i++)
            drive(1'b1, s[0], i, {$urandom, $urandom}, 1'b0, x);
   endtask

   initial begin
      int           x;
      logic [W-1:0] ones;
      logic [W-1:0] aaaa;
      model_clear();
      ones = '1;
      aaaa = {N{16'hAAAA}};

      // Reset held with start asserted
      rst   = 1'b0;
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk_bus("reset_h", horizontal_input, '0);
      chk_bus("reset_v", vertical_input, '0);
      chk_int("reset_busy", int'(busy), 0);
      chk_int("reset_fv", int'(feed_valid), 0);
      start = 1'b0;
      rst   = 1'b1;
      idle(2);

      // Feed order with the index pattern
      load_pattern();
      drive(1'b0, 1'b0, 0, '0, 1'b1, x);
      chk_bus("c1_h", horizontal_input, 64'h0000_0000_0000_0000);
      chk_bus("c1_v", vertical_input, 64'h0000_0000_0000_0100);
      idle(3);
      chk_bus("c4_h", horizontal_input, 64'h0030_0021_0012_0003);
      idle(3);
      chk_bus("c7_h", horizontal_input, 64'h0033_0000_0000_0000);
      chk_bus("c7_v", vertical_input, 64'h0133_0000_0000_0000);
      idle(9);
      chk_int("c16_done", int'(done), 1);
      chk_int("c16_busy", int'(busy), 1);
      idle(1);
      chk_int("c17_done", int'(done), 0);
      chk_int("c17_busy", int'(busy), 0);
      idle(3);

      // start and write while busy are ignored; a second run shows the original A
      drive(1'b0, 1'b0, 0, '0, 1'b1, x);
      drive(1'b1, 1'b0, 0, ones, 1'b1, x);
      idle(20);
      drive(1'b0, 1'b0, 0, '0, 1'b1, x);
      idle(20);

      // Write and start in the same idle cycle
      drive(1'b1, 1'b0, 0, aaaa, 1'b1, x);
      chk_bus("same_cycle_h", horizontal_input, 64'h0000_0000_0000_AAAA);
      idle(20);

      // Reset in the middle of a stream
      drive(1'b0, 1'b0, 0, '0, 1'b1, x);
      idle(2);
      @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
      #1;
      chk_bus("midrst_h", horizontal_input, '0);
      chk_bus("midrst_v", vertical_input, '0);
      chk_int("midrst_busy", int'(busy), 0);
      chk_int("midrst_fv", int'(feed_valid), 0);
      idle(2);
      rst = 1'b1;
      idle(25);
      load_random();
      drive(1'b0, 1'b0, 0, '0, 1'b1, x);
      idle(20);

      // Randomised runs with spurious start/write traffic
      for (int it = 0; it < 6; it++) begin
         load_random();
         drive(1'b0, 1'b0, 0, '0, 1'b1, x);
         for (int j = 0; j < 3; j++) begin
            idle($urandom_range(0, 4));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)), x);
         end
         idle(30);
      end

      idle(5);
      chk_int("feed_queue_drained", feed_q.size(), 0);
      chk_int("done_queue_drained", done_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
